ft2232h_rx_reader: RTL

- Receive-side companion to the FT2232H FT245 synchronous-FIFO transmit path. Reads bytes sent by the USB host out of the FT2232H RX FIFO (RXF#/OE#/RD# handshake on ADBUS) into an internal show-ahead FIFO.
- Presents the bytes to FPGA logic as a valid/ready byte stream.
- Sits between the FT2232H pins and downstream command/config logic. Runs entirely in the 60 MHz CLKOUT domain.

---
 rtl/ft2232h_rx_reader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ft2232h_rx_reader.sv
// ft2232h_rx_reader
//   Reads bytes from the FT2232H RX FIFO (FT245 synchronous mode: RXF#/OE#/RD#
//   on ADBUS) into an internal show-ahead FIFO. Presents them downstream as a
//   valid/ready byte stream. Everything runs on the 60 MHz CLKOUT domain.
//
// Ports
//   clk_i       CLKOUT from the FT2232H, rising edge
//   rst_n_i     asynchronous active-low reset
//   adbus_i     ADBUS[7:0] data (never driven by this block)
//   rxf_i       RXF#, low = FT2232H has data
//   oe_o        OE#, low = FT2232H drives ADBUS (registered)
//   rd_o        RD#, low = read/advance FT2232H FIFO (registered)
//   data_o      head byte of the internal FIFO
//   valid_o     data_o holds a byte
//   ready_i     consumer accepts data_o when valid_o && ready_i
//   level_o     internal FIFO occupancy, 0..FIFO_DEPTH
//   rx_count_o  total bytes captured
//
// Build option
//   FT_RX_BYTE_COUNT_EN : when defined, rx_count_o is a wrapping 32-bit count
//                         of captured bytes; otherwise it is tied to 0.
module ft2232h_rx_reader #(
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [7:0]                  adbus_i,
    input  logic                        rxf_i,
    output logic                        oe_o,
    output logic                        rd_o,
    output logic [7:0]                  data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic [31:0]                 rx_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OE_LO   = 2'd1,
        READING = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic            r_oe, r_rd, w_oe_next, w_rd_next;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [LW-1:0]   r_level, w_level_next, w_free_next;
    logic            w_capture, w_pop, w_room;

    assign w_capture    = !r_rd && !rxf_i;
    assign w_pop        = (r_level != '0) && ready_i;
    assign w_level_next = r_level + LW'(w_capture) - LW'(w_pop);
    assign w_free_next  = LW'(FIFO_DEPTH) - w_level_next;
    // Reading continues only while more than AF_MARGIN slots stay free after
    // this edge; that keeps every capture away from a full FIFO.
    assign w_room       = w_free_next > LW'(AF_MARGIN);

    // Next-state logic; OE#/RD# are computed here and registered below
    always_comb begin
        w_state_next = r_state;
        w_oe_next    = 1'b1;
        w_rd_next    = 1'b1;
        unique case (r_state)
            IDLE: begin
                if (!rxf_i && w_room) begin
                    w_state_next = OE_LO;
                    w_oe_next    = 1'b0;
                end
            end
            OE_LO: begin
                // One bus-turnaround cycle before RD# may fall
                if (rxf_i) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = READING;
                    w_oe_next    = 1'b0;
                    w_rd_next    = 1'b0;
                end
            end
            READING: begin
                if (rxf_i || !w_room) begin
                    w_state_next = IDLE;
                end else begin
                    w_oe_next = 1'b0;
                    w_rd_next = 1'b0;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_oe    <= 1'b1;
            r_rd    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_oe    <= w_oe_next;
            r_rd    <= w_rd_next;
        end
    end

    // Show-ahead FIFO; storage is cleared so data_o reads 0x00 out of reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_capture) begin
                r_mem[r_wptr] <= adbus_i;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_level <= w_level_next;
        end
    end

`ifdef FT_RX_BYTE_COUNT_EN
    logic [31:0] r_rx_count;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)      r_rx_count <= '0;
        else if (w_capture) r_rx_count <= r_rx_count + 32'd1;
    end
    assign rx_count_o = r_rx_count;
`else
    assign rx_count_o = '0;
`endif

    assign oe_o    = r_oe;
    assign rd_o    = r_rd;
    assign data_o  = r_mem[r_rptr];
    assign valid_o = (r_level != '0);
    assign level_o = r_level;

endmodule
